// File: rtl/pool_max_ctrl.sv
// pool_max_ctrl: sequences the running-max comparator over POOL_SIZE-sample windows.
// Latency: start->first in_ready 2 cycles, last accept->out_valid 1 cycle, last handshake->done 1 cycle.
// Backpressure: in_valid/in_ready upstream; EMIT holds out_valid/out_data (and stalls input) until out_ready.
// Optional macro POOL_ABORT_EN adds an abort input that returns the sequencer to IDLE from any busy state.
module pool_max_ctrl #(
  parameter int cmp_width = 4,
  parameter int POOL_SIZE = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     win_count,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [cmp_width-1:0] in_data,
  output logic                 cmp_clr,
  output logic [cmp_width-1:0] cmp_data,
  input  logic [cmp_width-1:0] cmp_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [cmp_width-1:0] out_data
`ifdef POOL_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  // Sample counter must be able to hold POOL_SIZE itself.
  localparam int SMP_W = $clog2(POOL_SIZE + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(POOL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  win_left;
  logic [SMP_W-1:0]  smp_cnt;

  // Counter control strobes produced by the next-state logic.
  logic              win_load;
  logic              win_dec;
  logic              smp_clr;
  logic              smp_inc;
  logic              abort_req;

  // Abort only matters once a sequence is underway; IDLE ignores it.
`ifdef POOL_ABORT_EN
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // busy covers the working states only; FIN (the done cycle) is not busy.
  assign busy = !rst && ((state == S_CLEAR) || (state == S_ACCUM) || (state == S_EMIT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Window and sample counters; win_left only decrements while nonzero.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_left <= '0;
      smp_cnt  <= '0;
    end else begin
      if (win_load) begin
        win_left <= win_count;
      end else if (win_dec) begin
        win_left <= win_left - CNT_W'(1);
      end
      if (smp_clr) begin
        smp_cnt <= '0;
      end else if (smp_inc) begin
        smp_cnt <= smp_cnt + SMP_W'(1);
      end
    end
  end

  // Next-state and output decode. Reset and abort clear the comparator and
  // block every handshake; cmp_data stays 0 unless a sample is accepted so the
  // free-running comparator keeps its max.
  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    win_dec   = 1'b0;
    smp_clr   = 1'b0;
    smp_inc   = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    cmp_data  = '0;
    cmp_clr   = 1'b0;

    if (rst) begin
      cmp_clr   = 1'b1;
      state_nxt = S_IDLE;
    end else if (abort_req) begin
      cmp_clr   = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (win_count != '0) begin
              win_load  = 1'b1;
              state_nxt = S_CLEAR;
            end else begin
              state_nxt = S_FIN;
            end
          end
        end

        S_CLEAR: begin
          cmp_clr   = 1'b1;
          smp_clr   = 1'b1;
          state_nxt = S_ACCUM;
        end

        S_ACCUM: begin
          in_ready = 1'b1;
          if (in_valid) begin
            cmp_data = in_data;
            smp_inc  = 1'b1;
            if (smp_cnt == SMP_LAST) begin
              state_nxt = S_EMIT;
            end
          end
        end

        S_EMIT: begin
          out_valid = 1'b1;
          out_data  = cmp_max;
          if (out_ready && (win_left != '0)) begin
            win_dec = 1'b1;
            if (win_left == CNT_W'(1)) begin
              state_nxt = S_FIN;
            end else begin
              state_nxt = S_CLEAR;
            end
          end
        end

        S_FIN: begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_max_ctrl.sv
// Testbench for pool_max_ctrl: directed windows against a window-level reference model.
// Drives inputs 1 time unit after the rising edge, samples everything on the falling edge.
// Includes a behavioural running-max comparator attached to cmp_clr/cmp_data/cmp_max.
module tb_pool_max_ctrl;

  localparam int W  = 4;
  localparam int PS = 4;
  localparam int CW = 8;

`ifdef POOL_ABORT_EN
  localparam bit AB_EN = 1'b1;
`else
  localparam bit AB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] win_count = '0;
  logic          busy;
  logic          done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          cmp_clr;
  logic [W-1:0]  cmp_data;
  logic [W-1:0]  cmp_max = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          abort = 1'b0;

  pool_max_ctrl #(.cmp_width(W), .POOL_SIZE(PS), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .win_count (win_count),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cmp_clr   (cmp_clr),
    .cmp_data  (cmp_data),
    .cmp_max   (cmp_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef POOL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  // Running-max comparator the controller sequences.
  always @(posedge clk) begin
    if (cmp_clr) cmp_max <= '0;
    else if (cmp_data > cmp_max) cmp_max <= cmp_data;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: tracks whether a run is active, which cycle is a clear
  // cycle, which cycle must carry done, and the queue of completed window
  // maxima waiting to be emitted.
  int cyc = 0;
  bit active = 1'b0;
  int wl = 0;
  int clr_cyc = -1;
  int done_cyc = -1;
  int win[$];
  int q[$];
  int hs_log[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    bit idle, ab, acc, e_ir, e_ov, e_clr, e_done, e_busy;
    int e_od, e_cd, m;
    idle   = !active && (cyc != done_cyc);
    ab     = AB_EN && abort && !rst && !idle;
    e_ir   = !rst && !ab && active && (cyc != clr_cyc) && (q.size() == 0);
    e_ov   = !rst && !ab && active && (q.size() != 0);
    acc    = in_valid && e_ir;
    e_cd   = acc ? int'(in_data) : 0;
    e_od   = e_ov ? q[0] : 0;
    e_clr  = rst || ab || (active && (cyc == clr_cyc));
    e_busy = !rst && active;
    e_done = !rst && !ab && (cyc == done_cyc);

    chk("in_ready",  int'(in_ready),  int'(e_ir));
    chk("out_valid", int'(out_valid), int'(e_ov));
    chk("out_data",  int'(out_data),  e_od);
    chk("cmp_data",  int'(cmp_data),  e_cd);
    chk("cmp_clr",   int'(cmp_clr),   int'(e_clr));
    chk("busy",      int'(busy),      int'(e_busy));
    chk("done",      int'(done),      int'(e_done));
    if (done) done_cnt++;

    if (rst || ab) begin
      active = 1'b0;
      q.delete();
      win.delete();
      done_cyc = -1;
      clr_cyc  = -1;
    end else begin
      if (idle && start) begin
        if (win_count == '0) done_cyc = cyc + 1;
        else begin
          active  = 1'b1;
          wl      = int'(win_count);
          clr_cyc = cyc + 1;
        end
      end
      if (acc) begin
        win.push_back(int'(in_data));
        if (win.size() == PS) begin
          m = 0;
          foreach (win[i]) if (win[i] > m) m = win[i];
          q.push_back(m);
          win.delete();
        end
      end
      if (e_ov && out_ready) begin
        hs_log.push_back(int'(out_data));
        void'(q.pop_front());
        wl--;
        if (wl == 0) begin
          active   = 1'b0;
          done_cyc = cyc + 1;
        end else begin
          clr_cyc = cyc + 1;
        end
      end
    end
    cyc++;
  end

  function automatic int log_at(input int i);
    return (i < hs_log.size()) ? hs_log[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int wc);
    start     = 1'b1;
    win_count = CW'(wc);
    step();
    start     = 1'b0;
  endtask

  task automatic send(input int v);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = W'(v);
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = 4'hF;
  endtask

  task automatic gap(input int n);
    idle_in();
    repeat (n) step();
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = done;
      step();
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int c0, d0;
    idle_in();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_in_ready", int'(in_ready), 0);
    chk("post_reset_cmp_clr", int'(cmp_clr), 0);
    step();

    // Single window, continuous input.
    do_start(1);
    send(3); send(9); send(2); send(7);
    idle_in();
    wait_done();
    chk("t1_max", log_at(0), 9);

    // Three windows; the last proves CLEAR removed the earlier 15.
    do_start(3);
    send(1); send(2); send(3); send(4);
    send(15); send(0); send(0); send(0);
    send(0); send(0); send(0); send(1);
    idle_in();
    wait_done();
    chk("t2_w0", log_at(1), 4);
    chk("t2_w1", log_at(2), 15);
    chk("t2_w2", log_at(3), 1);

    // Output backpressure for 5 cycles with the next sample waiting.
    out_ready = 1'b0;
    do_start(2);
    send(5); send(12); send(3); send(8);
    in_valid = 1'b1;
    in_data  = 4'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_data", int'(out_data), 12);
      chk("t3_hold_in_ready", int'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    c0 = cyc;
    send(6);
    chk("t3_accept_delay", cyc - c0, 3);
    send(1); send(2); send(3);
    idle_in();
    wait_done();
    chk("t3_w0", log_at(4), 12);
    chk("t3_w1", log_at(5), 6);

    // Input gaps with junk on in_data.
    do_start(1);
    send(6); gap(2); send(2); gap(1); send(11); send(4);
    idle_in();
    wait_done();
    chk("t4_max", log_at(6), 11);

    // Zero-window start, then a start while busy.
    d0 = done_cnt;
    do_start(0);
    @(negedge clk);
    chk("t5_zero_done", int'(done), 1);
    chk("t5_zero_busy", int'(busy), 0);
    step();
    chk("t5_zero_log", hs_log.size(), 7);
    do_start(1);
    send(7);
    idle_in();
    start     = 1'b1;
    win_count = 8'd5;
    step();
    start     = 1'b0;
    send(3); send(1); send(2);
    idle_in();
    wait_done();
    repeat (3) step();
    @(negedge clk);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_out_valid_after", int'(out_valid), 0);
    step();
    chk("t5_max", log_at(7), 7);
    chk("t5_done_cnt", done_cnt - d0, 2);

    // Reset mid-window, then a fresh run.
    do_start(2);
    send(9); send(8);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_cmp_clr", int'(cmp_clr), 1);
    chk("t6_rst_in_ready", int'(in_ready), 0);
    step();
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("t6_idle_busy", int'(busy), 0);
    step();
    repeat (3) step();
    chk("t6_no_done", done_cnt - d0, 0);
    do_start(1);
    send(1); send(1); send(1); send(1);
    idle_in();
    wait_done();
    chk("t6_fresh", log_at(8), 1);

`ifdef POOL_ABORT_EN
    // Abort mid-window with a sample offered during the abort cycle.
    do_start(2);
    send(9); send(8);
    in_valid = 1'b1;
    in_data  = 4'd13;
    abort    = 1'b1;
    @(negedge clk);
    chk("ab_cmp_clr", int'(cmp_clr), 1);
    chk("ab_in_ready", int'(in_ready), 0);
    chk("ab_out_valid", int'(out_valid), 0);
    step();
    abort = 1'b0;
    idle_in();
    d0 = done_cnt;
    @(negedge clk);
    chk("ab_idle_busy", int'(busy), 0);
    step();
    repeat (3) step();
    chk("ab_no_done", done_cnt - d0, 0);
    do_start(1);
    send(1); send(1); send(1); send(1);
    idle_in();
    wait_done();
    chk("ab_fresh", log_at(9), 1);
`endif

    chk("log_size", hs_log.size(), AB_EN ? 10 : 9);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
